ifft_sink_framer: RTL

//  Upstream feeder for the 1024-point IFFT control stage. Buffers a free-running

---
 rtl/ifft_sink_framer_if.sv | 41 ++++
 rtl/ifft_sink_framer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ifft_sink_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : ifft_sink_framer_if
// Purpose  : Sample-in / framed-stream-out bundle for ifft_sink_framer.
// Revision : 1.0 - initial release
// ============================================================================
interface ifft_sink_framer_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 2048
);
   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic signed [DATA_W-1:0] in_real;
   logic signed [DATA_W-1:0] in_imag;
   logic                     in_valid;
   logic                     in_ready;
   logic                     flush;
   logic signed [DATA_W-1:0] sink_real;
   logic signed [DATA_W-1:0] sink_imag;
   logic                     sink_valid;
   logic                     sink_sop;
   logic                     sink_eop;
   logic                     sink_ready;
   logic                     overflow;
   logic [FILL_W-1:0]        fill_level;

   // Environment side: upstream source plus IFFT sink
   modport master (
      output in_real, in_imag, in_valid, flush, sink_ready,
      input  in_ready, sink_real, sink_imag, sink_valid, sink_sop, sink_eop,
             overflow, fill_level
   );

   // Framer side
   modport slave (
      input  in_real, in_imag, in_valid, flush, sink_ready,
      output in_ready, sink_real, sink_imag, sink_valid, sink_sop, sink_eop,
             overflow, fill_level
   );
endinterface
`default_nettype wire

// File: rtl/ifft_sink_framer.sv
`default_nettype none
// ============================================================================
// Module   : ifft_sink_framer
// Purpose  : FIFO-buffered framer that re-emits a free-running complex sample
//            stream as sop/eop-delimited frames for the IFFT sink.
// Options  : IFFT_FRAMER_ZERO_PAD_EN - flush pads a partial frame with zeros.
// Revision : 1.0 - initial release
// ============================================================================
module ifft_sink_framer #(
   parameter int N_POINTS   = 1024,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 2048
) (
   input  wire logic         clk,
   input  wire logic         reset,
   ifft_sink_framer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;
   localparam int CW = $clog2(N_POINTS);
   localparam int WW = 2 * DATA_W;
   localparam logic [FW-1:0] C_DEPTH = FW'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_LAST  = CW'(N_POINTS - 1);

`ifdef IFFT_FRAMER_ZERO_PAD_EN
   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, PAD = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1} state_t;
`endif

   state_t          r_state;
   state_t          w_state_nxt;
   logic [WW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [FW-1:0]   r_mem_cnt;
   logic [WW-1:0]   r_head;
   logic            r_head_valid;
   logic            r_ready_en;
   logic            r_overflow;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [FW-1:0]   w_fill;
   logic [FW-1:0]   w_fill_nxt;
   logic            w_full;
   logic            w_in_ready;
   logic            w_push;
   logic            w_pop;
   logic            w_load;
   logic            w_in_pad;
   logic            w_valid;
   logic            w_xfer;
   logic            w_last;

   // Occupancy counts the registered head as well as the storage array
   assign w_fill     = r_mem_cnt + FW'(r_head_valid);
   assign w_full     = (w_fill == C_DEPTH);
   assign w_in_ready = r_ready_en && !w_full;
   assign w_push     = bus.in_valid && w_in_ready;

   assign w_valid = ((r_state == STREAM) && r_head_valid) || w_in_pad;
   assign w_xfer  = w_valid && bus.sink_ready;
   assign w_last  = (r_cnt == C_LAST);
   assign w_pop   = w_xfer && !w_in_pad;
   assign w_load  = (r_mem_cnt != '0) && (!r_head_valid || w_pop);

   assign w_fill_nxt = w_fill + FW'(w_push) - FW'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.in_real, bus.in_imag};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_mem_cnt    <= '0;
         r_head       <= '0;
         r_head_valid <= 1'b0;
         r_ready_en   <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_load) begin
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_head       <= r_mem[r_rd_ptr];
            r_head_valid <= 1'b1;
         end else if (w_pop) begin
            r_head_valid <= 1'b0;
         end
         r_mem_cnt <= r_mem_cnt + FW'(w_push) - FW'(w_load);
         if (bus.in_valid && !w_in_ready) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef IFFT_FRAMER_ZERO_PAD_EN
   logic r_pad_req;

   assign w_in_pad = (r_state == PAD);

   // A flush only matters for a frame that has already started
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pad_req <= 1'b0;
      end else if (w_xfer && w_last) begin
         r_pad_req <= 1'b0;
      end else if (bus.flush && (r_state == STREAM) && (r_cnt != '0)) begin
         r_pad_req <= 1'b1;
      end
   end
`else
   logic unused_flush;

   assign w_in_pad     = 1'b0;
   assign unused_flush = bus.flush;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_fill != '0) begin
               w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (w_xfer) begin
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (w_fill_nxt == '0) begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
`ifdef IFFT_FRAMER_ZERO_PAD_EN
            end else if (r_pad_req && (w_fill == '0)) begin
               w_state_nxt = PAD;
`endif
            end
         end
`ifdef IFFT_FRAMER_ZERO_PAD_EN
         PAD: begin
            if (w_xfer) begin
               if (w_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.sink_real  = w_in_pad ? '0 : r_head[WW-1:DATA_W];
   assign bus.sink_imag  = w_in_pad ? '0 : r_head[DATA_W-1:0];
   assign bus.sink_valid = w_valid;
   assign bus.sink_sop   = w_valid && (r_cnt == '0);
   assign bus.sink_eop   = w_valid && w_last;
   assign bus.overflow   = r_overflow;
   assign bus.fill_level = w_fill;

endmodule
`default_nettype wire
